branch_unit_ctrl: RTL
=====================

// Module: branch_unit_ctrl
// PURPOSE
//  Parametrised branch-resolution controller: classifies each resolved branch, buffers
//  outcomes in a DEPTH-entry FIFO, delivers them via valid/ready to fetch/predictor.
//  After a mispredict, stops accepting wrong-path branches until flush_i.
//  Sits between branch ALU (taken/wrong_* flags) and frontend; also keeps statistics.
// PARAMETERS
//  DEPTH  2   outcome FIFO entries (>=1; need not be a power of 2)
//  XLEN   32  width of pc/target fields (matches resolution_t in mmm_pkg)
//  CNT_W  32  width of branch/mispredict statistics counters (saturating)
// PORTS
//  clk_i           in   1      clock, rising edge
//  rst_n_i         in   1      reset, asynchronous, active-low
//  ops_valid_i     in   1      branch operands/flags valid
//  ops_ready_o     out  1      controller can accept a branch this cycle
//  taken_i         in   1      branch evaluated taken
//  wrong_taken_i   in   1      predicted direction differs from taken_i
//  wrong_target_i  in   1      predicted target differs (meaningful only if taken_i)
//  pc_i            in   XLEN   branch PC
//  target_i        in   XLEN   computed branch target
//  flush_i         in   1      frontend redirect done: drop queue, resume accepting
//  res_ready_i     in   1      consumer accepts head outcome
//  res_o           out  resolution_t  head outcome; res_o.valid = FIFO non-empty
//  n_branch_o      out  CNT_W  branches accepted since reset
//  n_mispred_o     out  CNT_W  mispredicted branches accepted since reset
// BEHAVIOUR
//  Reset: state=RESET, FIFO empty, counters 0; ops_ready_o=0, res_o all-zero.
//  FSM: RESET -> RUN (unconditional, 1 cycle). RUN: accept = ops_valid_i && ops_ready_o;
//   accept with mispredict -> HOLD, else stay RUN. HOLD -> RUN on flush_i, else HOLD.
//  flush_i has priority in every state except RESET: FIFO emptied, -> RUN, no push that
//   cycle even if ops_valid_i; counters unaffected. flush_i in RESET ignored.
//  ops_ready_o = (state==RUN) && !full; registered-state only, no path from res_ready_i.
//  Classification on accept: mispredict = taken_i ? (wrong_taken_i|wrong_target_i)
//   : wrong_taken_i; taken = taken_i; pc = pc_i;
//   target = taken_i ? target_i : pc_i+4 (XLEN-bit wrap-around, carry discarded).
//  Push on accept; entry visible on res_o the cycle after accept (1-cycle latency).
//  Pop when res_o.valid && res_ready_i; res_o holds stable while valid && !res_ready_i.
//  Simultaneous push+pop when full: not possible (ops_ready_o=0 when full);
//   when non-full and non-empty, push and pop in same cycle keep count unchanged.
//  Empty: res_o.valid=0 and pc/target/taken/mispredict driven 0.
//  Counters: +1 per accept (n_mispred_o only if mispredict); saturate at all-ones.
//  Pointers wrap modulo DEPTH; occupancy counter width $clog2(DEPTH+1).
//  Async reset mid-operation: all state cleared immediately, queued outcomes lost.
// STRUCTURE
//  mmm_pkg: resolution_t (existing), new bu_state_t {RESET,RUN,HOLD}, BRANCH_INSN_BYTES=4.
//  Sub-module: branch_outcome_fifo (generic DEPTH x resolution_t, push/pop/full/empty,
//   flush); top holds FSM, classification, counters.
// TESTING
//  1 Reset, DEPTH=2: ops_valid_i=1 held -> ops_ready_o=0 cycle 0, =1 from cycle 1;
//    taken=1, no wrong, pc=0x100, target=0x200 -> next cycle res_o={0x100,0x200,t=1,m=0,v=1}.
//  2 Not-taken, wrong_taken=1, pc=0xFFFFFFFC -> res_o.target=0x0, mispredict=1,
//    ops_ready_o=0 (HOLD) until flush_i; n_mispred_o=1.
//  3 res_ready_i=0, 2 good branches -> full, ops_ready_o=0, res_o stable; raise
//    res_ready_i -> pops in order (FIFO order), ops_ready_o=1 next cycle.
//  4 flush_i with 2 entries queued and ops_valid_i=1 -> next cycle res_o.valid=0,
//    no entry pushed, state RUN; counters unchanged.
//  5 Counters with CNT_W=3: 9 accepted branches -> n_branch_o=7 (saturated).
//  6 rst_n_i low mid-stream with full FIFO -> res_o.valid=0, counters 0 without clock edge.

Source files
------------

// File: rtl/mmm_pkg.sv
// ----------------------------------------------------------------------------
// mmm_pkg
//   Shared types for the branch-resolution path.
//   - resolution_t : one resolved-branch outcome as seen by fetch/predictor
//   - bu_state_t   : branch_unit_ctrl acceptance state
//   - BRANCH_INSN_BYTES : fall-through distance for a not-taken branch
// ----------------------------------------------------------------------------
package mmm_pkg;

    localparam int RES_XLEN          = 32;
    localparam int BRANCH_INSN_BYTES = 4;

    typedef struct packed {
        logic [RES_XLEN-1:0] pc;
        logic [RES_XLEN-1:0] target;
        logic                taken;
        logic                mispredict;
        logic                valid;
    } resolution_t;

    typedef enum logic [1:0] {
        RESET = 2'd0,
        RUN   = 2'd1,
        HOLD  = 2'd2
    } bu_state_t;

    // A not-taken branch can only be wrong on direction; a taken branch can
    // be wrong on direction or on the predicted target.
    function automatic logic is_mispredict(input logic taken,
                                           input logic wrong_taken,
                                           input logic wrong_target);
        return taken ? (wrong_taken | wrong_target) : wrong_taken;
    endfunction

endpackage : mmm_pkg

// File: rtl/branch_unit_ctrl_if.sv
// ----------------------------------------------------------------------------
// branch_unit_ctrl_if
//   Bundles the branch-ALU side (operands/flags + handshake), the frontend
//   side (flush, outcome valid/ready) and the statistics counters.
//   master : branch ALU / frontend (drives *_i, observes *_o)
//   slave  : branch_unit_ctrl
// ----------------------------------------------------------------------------
interface branch_unit_ctrl_if #(
    parameter int XLEN  = mmm_pkg::RES_XLEN,
    parameter int CNT_W = 32
);
    import mmm_pkg::*;

    logic              ops_valid_i;
    logic              ops_ready_o;
    logic              taken_i;
    logic              wrong_taken_i;
    logic              wrong_target_i;
    logic [XLEN-1:0]   pc_i;
    logic [XLEN-1:0]   target_i;
    logic              flush_i;
    logic              res_ready_i;
    resolution_t       res_o;
    logic [CNT_W-1:0]  n_branch_o;
    logic [CNT_W-1:0]  n_mispred_o;

    modport master (
        output ops_valid_i, taken_i, wrong_taken_i, wrong_target_i,
               pc_i, target_i, flush_i, res_ready_i,
        input  ops_ready_o, res_o, n_branch_o, n_mispred_o
    );

    modport slave (
        input  ops_valid_i, taken_i, wrong_taken_i, wrong_target_i,
               pc_i, target_i, flush_i, res_ready_i,
        output ops_ready_o, res_o, n_branch_o, n_mispred_o
    );

endinterface : branch_unit_ctrl_if

// File: rtl/branch_outcome_fifo.sv
// ----------------------------------------------------------------------------
// branch_outcome_fifo
//   DEPTH-entry FIFO of resolution_t (DEPTH >= 1, any value, not only 2^n).
//   Ports:
//     clk_i, rst_n_i  clock / async active-low reset
//     flush_i         drop all entries (overrides push and pop)
//     push_i, push_data_i   write one entry (ignored when full)
//     pop_i           retire head entry (ignored when empty)
//     head_o          head entry; all-zero with valid=0 when empty
//     full_o, empty_o occupancy flags
// ----------------------------------------------------------------------------
module branch_outcome_fifo
    import mmm_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        flush_i,
    input  logic        push_i,
    input  resolution_t push_data_i,
    input  logic        pop_i,
    output resolution_t head_o,
    output logic        full_o,
    output logic        empty_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] count_q,  count_d;
    logic             push_ok, pop_ok;

    resolution_t mem_q [DEPTH];

    // Pointers wrap explicitly so a non-power-of-2 DEPTH works.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full_o  = (count_q == OCC_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign push_ok = push_i && !full_o  && !flush_i;
    assign pop_ok  = pop_i  && !empty_o && !flush_i;

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = next_ptr(wr_ptr_q);
            if (pop_ok)  rd_ptr_d = next_ptr(rd_ptr_q);
            unique case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + OCC_W'(1);
                2'b01:   count_d = count_q - OCC_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge value of every other flop.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; empty_o masks stale contents,
    // which keeps the array a plain RAM/regfile without reset muxes.
    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
    end

    always_comb begin
        head_o = '0;
        if (!empty_o) begin
            head_o       = mem_q[rd_ptr_q];
            head_o.valid = 1'b1;
        end
    end

endmodule : branch_outcome_fifo

// File: rtl/branch_unit_ctrl.sv
// ----------------------------------------------------------------------------
// branch_unit_ctrl
//   Branch-resolution controller between the branch ALU and the frontend.
//   Classifies each accepted branch, queues the outcome in a DEPTH-entry FIFO
//   delivered over valid/ready, and stops accepting after a mispredict until
//   the frontend signals flush_i. Also keeps saturating statistics.
//   Ports:
//     clk_i, rst_n_i  clock / async active-low reset
//     bu (slave)      ops_valid_i/ops_ready_o, taken_i, wrong_taken_i,
//                     wrong_target_i, pc_i, target_i, flush_i,
//                     res_ready_i/res_o, n_branch_o, n_mispred_o
//   XLEN must equal mmm_pkg::RES_XLEN (resolution_t field width).
// ----------------------------------------------------------------------------
module branch_unit_ctrl
    import mmm_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int XLEN  = RES_XLEN,
    parameter int CNT_W = 32
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    branch_unit_ctrl_if.slave  bu
);

    bu_state_t        state_q, state_d;
    logic [CNT_W-1:0] n_branch_q,  n_branch_d;
    logic [CNT_W-1:0] n_mispred_q, n_mispred_d;

    logic             fifo_full, fifo_empty;
    logic             fifo_flush;
    logic             accept;
    logic             mispredict;
    logic             pop;
    logic [XLEN-1:0]  fall_through;
    resolution_t      entry;
    resolution_t      head;

    // Ready depends on registered state only, never on res_ready_i, so the
    // frontend's ready cannot form a combinational loop through the ALU.
    assign bu.ops_ready_o = (state_q == RUN) && !fifo_full;

    // A flush in the same cycle cancels the push (and the statistics update).
    assign accept     = bu.ops_valid_i && bu.ops_ready_o && !bu.flush_i;
    assign fifo_flush = bu.flush_i && (state_q != RESET);
    assign pop        = !fifo_empty && bu.res_ready_i;

    assign mispredict   = is_mispredict(bu.taken_i, bu.wrong_taken_i, bu.wrong_target_i);
    // Carry out of the PC is discarded: the sequential PC wraps at 2^XLEN.
    assign fall_through = bu.pc_i + XLEN'(BRANCH_INSN_BYTES);

    always_comb begin
        entry            = '0;
        entry.pc         = bu.pc_i;
        entry.target     = bu.taken_i ? bu.target_i : fall_through;
        entry.taken      = bu.taken_i;
        entry.mispredict = mispredict;
        entry.valid      = 1'b1;
    end

    branch_outcome_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .flush_i     (fifo_flush),
        .push_i      (accept),
        .push_data_i (entry),
        .pop_i       (pop),
        .head_o      (head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    assign bu.res_o = head;

    // State machine: one idle cycle out of reset, then RUN; a mispredicted
    // branch parks it in HOLD so wrong-path branches are not accepted.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RESET: state_d = RUN;
            RUN: begin
                if (bu.flush_i)                  state_d = RUN;
                else if (accept && mispredict)   state_d = HOLD;
            end
            HOLD: begin
                if (bu.flush_i)                  state_d = RUN;
            end
            default: state_d = RESET;
        endcase
    end

    // Saturating counters: stick at all-ones rather than wrapping to zero.
    always_comb begin
        n_branch_d  = n_branch_q;
        n_mispred_d = n_mispred_q;
        if (accept) begin
            if (n_branch_q != '1)
                n_branch_d = n_branch_q + CNT_W'(1);
            if (mispredict && (n_mispred_q != '1))
                n_mispred_d = n_mispred_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= RESET;
            n_branch_q  <= '0;
            n_mispred_q <= '0;
        end else begin
            state_q     <= state_d;
            n_branch_q  <= n_branch_d;
            n_mispred_q <= n_mispred_d;
        end
    end

    assign bu.n_branch_o  = n_branch_q;
    assign bu.n_mispred_o = n_mispred_q;

endmodule : branch_unit_ctrl
